// File: rtl/jesd_tx_pkg.sv
// Shared JESD204B transmit definitions: control-character octets and sequencer state encoding.
package jesd_tx_pkg;

    typedef enum logic [1:0] {
        ST_CGS  = 2'd0,
        ST_ILAS = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [7:0] K28_0 = 8'h1C;  // /R/ multiframe start
    localparam logic [7:0] K28_3 = 8'h7C;  // /A/ multiframe end
    localparam logic [7:0] K28_4 = 8'h9C;  // /Q/ config data follows
    localparam logic [7:0] K28_5 = 8'hBC;  // /K/ comma
    localparam logic [7:0] K28_7 = 8'hFC;  // /F/ frame end

endpackage

// File: rtl/jesd_lmfc_cnt.sv
// Free-running octet-in-multiframe counter with a registered LMFC marker.
module jesd_lmfc_cnt #(
    parameter int FK = 32,
    parameter int W  = (FK > 1) ? $clog2(FK) : 1
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] oc,
    output logic         last,
    output logic         lmfc
);

    assign last = (oc == W'(FK - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oc   <= '0;
            lmfc <= 1'b0;
        end else begin
            oc   <= last ? '0 : oc + W'(1);
            lmfc <= (oc == '0);
        end
    end

endmodule

// File: rtl/jesd_tx_seq.sv
// JESD204B transmit link sequencer (CGS -> ILAS -> DATA) feeding an 8b10b encoder ROM.
// Define JESD_CHAR_REPLACE_EN to enable frame/multiframe-end character replacement in DATA.
module jesd_tx_seq
    import jesd_tx_pkg::*;
#(
    parameter int F       = 1,
    parameter int K       = 32,
    parameter int ILAS_MF = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_sync_n,
    input  logic [7:0] i_data,
    output logic       o_data_rdy,
    output logic [7:0] o_addr,
    output logic       o_k,
    output logic       o_rd_en,
    output logic [1:0] o_state,
    output logic       o_lmfc
);

    localparam int FK  = F * K;
    localparam int OCW = (FK > 1) ? $clog2(FK) : 1;

    logic [OCW-1:0] oc;
    logic           oc_last;
    logic [7:0]     oc_octet;
    state_t         state;
    logic [7:0]     mf;
    logic [7:0]     data_oct;
    logic           data_k;

    jesd_lmfc_cnt #(
        .FK (FK),
        .W  (OCW)
    ) u_lmfc (
        .clk  (clk),
        .rst  (rst),
        .oc   (oc),
        .last (oc_last),
        .lmfc (o_lmfc)
    );

    assign oc_octet = 8'(oc);
    assign o_state  = state;

`ifdef JESD_CHAR_REPLACE_EN
    localparam int FW = (F > 1) ? $clog2(F) : 1;

    logic [FW-1:0] fc;
    logic          frame_end;
    logic [7:0]    prev;

    assign frame_end = (fc == FW'(F - 1));

    // Frame position tracker; F divides F*K so it stays aligned with oc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fc <= '0;
        end else begin
            fc <= frame_end ? '0 : fc + FW'(1);
        end
    end

    // Holds the unreplaced last octet of the previous frame; zero outside DATA.
    always_ff @(posedge clk) begin
        if (state != ST_DATA) begin
            prev <= 8'h00;
        end else if (frame_end) begin
            prev <= i_data;
        end
    end

    always_comb begin
        data_oct = i_data;
        data_k   = 1'b0;
        if (frame_end && (i_data == prev)) begin
            data_k   = 1'b1;
            data_oct = oc_last ? K28_3 : K28_7;
        end
    end
`else
    assign data_oct = i_data;
    assign data_k   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_CGS;
            mf         <= 8'd0;
            o_addr     <= 8'h00;
            o_k        <= 1'b0;
            o_rd_en    <= 1'b0;
            o_data_rdy <= 1'b0;
        end else begin
            o_rd_en <= 1'b1;
            // Loss of SYNC~ drops straight back to comma emission, no LMFC alignment.
            if ((state != ST_CGS) && !i_sync_n) begin
                state      <= ST_CGS;
                mf         <= 8'd0;
                o_addr     <= K28_5;
                o_k        <= 1'b1;
                o_data_rdy <= 1'b0;
            end else begin
                case (state)
                    ST_CGS: begin
                        o_addr <= K28_5;
                        o_k    <= 1'b1;
                        mf     <= 8'd0;
                        if (i_sync_n && oc_last) begin
                            state <= ST_ILAS;
                        end
                    end
                    ST_ILAS: begin
                        if (oc == '0) begin
                            o_addr <= K28_0;
                            o_k    <= 1'b1;
                        end else if (oc_last) begin
                            o_addr <= K28_3;
                            o_k    <= 1'b1;
                        end else if ((mf == 8'd1) && (oc == OCW'(1))) begin
                            o_addr <= K28_4;
                            o_k    <= 1'b1;
                        end else begin
                            o_addr <= oc_octet;
                            o_k    <= 1'b0;
                        end
                        if (oc_last) begin
                            if (mf == 8'(ILAS_MF - 1)) begin
                                state      <= ST_DATA;
                                o_data_rdy <= 1'b1;
                            end else begin
                                mf <= mf + 8'd1;
                            end
                        end
                    end
                    ST_DATA: begin
                        o_addr     <= data_oct;
                        o_k        <= data_k;
                        o_data_rdy <= 1'b1;
                    end
                    default: begin
                        state      <= ST_CGS;
                        o_addr     <= K28_5;
                        o_k        <= 1'b1;
                        o_data_rdy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/jesd_tx_seq.md
JESD_TX_SEQ -- requirements
Module: jesd_tx_seq

Interface
REQ-001 SHALL have parameter F, default 1, octets per frame (1..8).
REQ-002 SHALL have parameter K, default 32, frames per multiframe (F*K in 4..256).
REQ-003 SHALL have parameter ILAS_MF, default 4, number of ILAS multiframes.
REQ-004 SHALL have port clk, input, 1, sole clock; everything rising-edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port i_sync_n, input, 1, JESD SYNC~; low requests code-group sync.
REQ-007 SHALL have port i_data, input, 8, link payload octet HGFEDCBA.
REQ-008 SHALL have port o_data_rdy, output, 1, i_data consumed this cycle.
REQ-009 SHALL have port o_addr, output, 8, octet to 8b10b encoder ROM address.
REQ-010 SHALL have port o_k, output, 1, 1 = control character, 0 = data.
REQ-011 SHALL have port o_rd_en, output, 1, encoder ROM read enable.
REQ-012 SHALL have port o_state, output, 2, 0 = CGS, 1 = ILAS, 2 = DATA.
REQ-013 SHALL have port o_lmfc, output, 1, pulse on the first octet of each multiframe.

Function
REQ-014 SHALL keep a free-running octet counter oc, 0..F*K-1, wrapping to 0; o_lmfc SHALL be registered (oc==0).
REQ-015 SHALL use states CGS, ILAS, DATA, with every output registered, so the encoder sees each octet 1 cycle after the decision.
REQ-016 SHALL emit K28.5 (o_addr=8'hBC, o_k=1) every cycle in CGS.
REQ-017 SHALL go CGS->ILAS only when i_sync_n is high and oc wraps to 0; ILAS SHALL start on octet 0.
REQ-018 SHALL, in ILAS multiframe m (0..ILAS_MF-1), emit: octet 0 K28.0; octet F*K-1 K28.3; for m==1 only, octet 1 K28.4; all other octets data = oc[7:0] with o_k=0.
REQ-019 SHALL go ILAS->DATA after the final octet of multiframe ILAS_MF-1.
REQ-020 SHALL assert o_data_rdy only in DATA; the accepted i_data SHALL appear on o_addr, with o_k=0, on the next cycle.
REQ-021 SHALL return to CGS on the cycle after i_sync_n is sampled low in ILAS or DATA (no multiframe alignment), dropping o_data_rdy in that same cycle.
REQ-022 SHALL hold o_rd_en at 1 in every state after the first post-reset cycle.
REQ-023 SHALL treat i_sync_n low at the instant oc wraps as remaining in CGS, since low wins over the transition.

Reset
REQ-024 SHALL, while rst is high: state CGS, oc 0, o_addr 8'h00, o_k 0, o_rd_en 0, o_data_rdy 0, o_lmfc 0, o_state 0.
REQ-025 SHALL emit the first K28.5 on the 1st rising edge after rst falls, and restart ILAS from multiframe 0 after any reset mid-ILAS.

Configuration
REQ-026 SHALL implement character replacement under JESD_CHAR_REPLACE_EN.
REQ-027 SHALL, with the macro defined, in DATA: if the last octet of a frame equals the last octet of the previous frame, send K28.3 (8'h7C) when oc==F*K-1, otherwise K28.7 (8'hFC), o_k=1. The previous-frame register SHALL hold the original data and SHALL clear on entering DATA.
REQ-028 SHALL, without the macro, pass data unmodified and omit the previous-frame register.

Structure
REQ-029 SHALL place K28.0/3/4/5/7 octet constants and the state encoding in package jesd_tx_pkg.
REQ-030 SHALL use one sub-module, jesd_lmfc_cnt, which holds the octet counter and o_lmfc (parameter F*K).

Verification (F=1, K=4, ILAS_MF=4)
REQ-031 SHALL cover: rst high 3 cycles, i_sync_n low -> o_addr 8'h00/o_rd_en 0 during reset, then continuous 8'hBC, o_k=1.
REQ-032 SHALL cover: i_sync_n rises at oc=2 -> CGS until oc=0, then ILAS MF0 = 1C,01,02,7C (k 1,0,0,1); MF1 = 1C,9C,02,7C.
REQ-033 SHALL cover: after 16 ILAS octets -> o_state=2, o_data_rdy=1; i_data 8'h11,22,33 -> o_addr 11,22,33 one cycle later.
REQ-034 SHALL cover: i_sync_n low in DATA -> next cycle o_state=0, o_data_rdy=0, o_addr 8'hBC.
REQ-035 SHALL cover, with JESD_CHAR_REPLACE_EN: i_data 8'h55 repeated at oc 0..3 -> 55, FC, FC, 7C; without the macro -> 55, 55, 55, 55.
REQ-036 SHALL cover: rst pulse during ILAS MF2 -> outputs reset; after release, CGS then ILAS from MF0.
